// File: rtl/csa_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// csa_seq_ctrl_pkg
//
// Purpose : Definitions shared by the sequential carry-skip adder controller
//           and its bench. It holds the FSM state encoding, the default
//           parameter values and a helper that sizes the beat counter.
//
// Contents:
//   DEF_ADDER_SIZE  default width of one carry-skip adder slice
//   DEF_GROUP_SIZE  default skip-group size inside the slice adder
//   DEF_BEATS       default number of slices per operation
//   state_e         controller state encoding (IDLE / RUN / DONE)
//   beat_cnt_width  beat counter width, max(1, clog2(beats))
// -----------------------------------------------------------------------------
package csa_seq_ctrl_pkg;

    localparam int DEF_ADDER_SIZE = 8;
    localparam int DEF_GROUP_SIZE = 2;
    localparam int DEF_BEATS      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-beat configuration still needs a one-bit counter so that the
    // counter flop and its compare logic stay well formed.
    function automatic int beat_cnt_width(input int beats);
        if (beats <= 1) begin
            return 1;
        end
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/CSA_p.sv
// -----------------------------------------------------------------------------
// CSA_p
//
// Purpose : Combinational carry-skip adder of ADDER_SIZE bits. Bits are split
//           into groups of GROUP_SIZE; inside a group the carry ripples, and a
//           group whose bits all propagate forwards its carry-in directly to
//           its carry-out (the skip path). The last group may be shorter when
//           ADDER_SIZE is not a multiple of GROUP_SIZE.
//
// Ports   :
//   A, B  in  [ADDER_SIZE:1]  addends
//   CIN   in  1               carry-in
//   SUM   out [ADDER_SIZE:1]  sum
//   COUT  out 1               carry-out
// -----------------------------------------------------------------------------
module CSA_p #(
    parameter int ADDER_SIZE = 8,
    parameter int GROUP_SIZE = 2
) (
    input  logic [ADDER_SIZE:1] A,
    input  logic [ADDER_SIZE:1] B,
    input  logic                CIN,
    output logic [ADDER_SIZE:1] SUM,
    output logic                COUT
);

    logic [ADDER_SIZE:1] prop;
    logic [ADDER_SIZE:1] gen;
    // carry[i] is the carry out of bit i; carry[0] is the adder carry-in.
    logic [ADDER_SIZE:0] carry;
    logic                grp_prop;
    logic                grp_cin;
    logic                ripple;

    always_comb begin
        prop     = A ^ B;
        gen      = A & B;
        carry    = '0;
        carry[0] = CIN;
        grp_prop = 1'b0;
        grp_cin  = 1'b0;
        ripple   = 1'b0;
        SUM      = '0;

        for (int i = 1; i <= ADDER_SIZE; i++) begin
            // First bit of a group: latch the group carry-in, restart the
            // group propagate product.
            if (((i - 1) % GROUP_SIZE) == 0) begin
                grp_prop = 1'b1;
                grp_cin  = carry[i-1];
            end
            grp_prop = grp_prop & prop[i];
            ripple   = gen[i] | (prop[i] & carry[i-1]);

            // Last bit of a group: the skip mux picks the group carry-in
            // when every bit of the group propagates.
            if (((i % GROUP_SIZE) == 0) || (i == ADDER_SIZE)) begin
                carry[i] = grp_prop ? grp_cin : ripple;
            end else begin
                carry[i] = ripple;
            end

            SUM[i] = prop[i] ^ carry[i-1];
        end

        COUT = carry[ADDER_SIZE];
    end

endmodule

// File: rtl/csa_seq_ctrl.sv
// -----------------------------------------------------------------------------
// csa_seq_ctrl
//
// Purpose : Multi-cycle adder. One operation of W = ADDER_SIZE*BEATS bits is
//           added one ADDER_SIZE slice per clock through a single carry-skip
//           slice adder (CSA_p), least significant slice first, with the
//           slice carry held in a carry register between beats.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
//           high. IN_READY is high only in IDLE, OUT_VALID only in DONE. A
//           result is held stable in DONE until an edge with OUT_READY high;
//           OUT_READY is ignored in every other state. A new operation cannot
//           be accepted on the edge its predecessor's result is taken.
//
// Ports   :
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   IN_VALID   in   operation offered
//   IN_READY   out  operation can be accepted (IDLE)
//   A, B       in   [W:1] operands
//   CIN        in   operation carry-in
//   OUT_VALID  out  result valid (DONE)
//   OUT_READY  in   result taken
//   SUM        out  [W:1] result
//   COUT       out  result carry-out
//   BUSY       out  state is not IDLE
//   DBG_STATE  out  current FSM state, for observation only
//
// Timing  : operation accepted at edge t -> OUT_VALID from edge t+BEATS.
// -----------------------------------------------------------------------------
module csa_seq_ctrl
    import csa_seq_ctrl_pkg::*;
#(
    parameter int ADDER_SIZE = DEF_ADDER_SIZE,
    parameter int GROUP_SIZE = DEF_GROUP_SIZE,
    parameter int BEATS      = DEF_BEATS
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [ADDER_SIZE*BEATS:1]  A,
    input  logic [ADDER_SIZE*BEATS:1]  B,
    input  logic                       CIN,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [ADDER_SIZE*BEATS:1]  SUM,
    output logic                       COUT,
    output logic                       BUSY,
    output state_e                     DBG_STATE
);

    localparam int W  = ADDER_SIZE * BEATS;
    localparam int CW = beat_cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            carry_q,     carry_d;
    logic [W:1]      a_q,         a_d;
    logic [W:1]      b_q,         b_d;
    logic [W:1]      sum_q,       sum_d;
    logic            cout_q,      cout_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q,      busy_d;

    // -------------------------------------------------------------------------
    // Slice datapath: operand slice k selected by the beat counter
    // -------------------------------------------------------------------------
    logic [ADDER_SIZE:1] slice_a;
    logic [ADDER_SIZE:1] slice_b;
    logic [ADDER_SIZE:1] slice_sum;
    logic                slice_cout;
    int                  slice_lo;

    always_comb begin
        slice_lo = int'(cnt_q) * ADDER_SIZE + 1;
        slice_a  = a_q[slice_lo +: ADDER_SIZE];
        slice_b  = b_q[slice_lo +: ADDER_SIZE];
    end

    CSA_p #(
        .ADDER_SIZE (ADDER_SIZE),
        .GROUP_SIZE (GROUP_SIZE)
    ) u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .CIN  (carry_q),
        .SUM  (slice_sum),
        .COUT (slice_cout)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                // SUM/COUT keep the previous result while idle; they are only
                // overwritten slice by slice once the next operation runs.
                if (IN_VALID && in_ready_q) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d[slice_lo +: ADDER_SIZE] = slice_sum;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BEAT) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake/status outputs are registered and follow the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign BUSY      = busy_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csa_seq_ctrl
//
// Bench for csa_seq_ctrl with ADDER_SIZE=8, GROUP_SIZE=2, BEATS=2 (W=16).
// Known vectors from a table, randomized operations against an arithmetic
// reference (A+B+CIN), plus hand sequences for backpressure and reset mid-RUN.
// -----------------------------------------------------------------------------
module tb_csa_seq_ctrl;
    import csa_seq_ctrl_pkg::*;

    localparam int AS    = 8;
    localparam int GS    = 2;
    localparam int BEATS = 2;
    localparam int W     = AS * BEATS;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT
    // -------------------------------------------------------------------------
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [W:1]  A;
    logic [W:1]  B;
    logic        CIN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [W:1]  SUM;
    logic        COUT;
    logic        BUSY;
    state_e      DBG_STATE;

    always #5 CLK = ~CLK;

    csa_seq_ctrl #(
        .ADDER_SIZE (AS),
        .GROUP_SIZE (GS),
        .BEATS      (BEATS)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [W:0]  exp_q[$];
    logic [W:0]  last_res = '0;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit addition.
    function automatic logic [W:0] ref_add(input logic [W:1] a, input logic [W:1] b, input logic c);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Driver: one full operation with an optional backpressure hold in DONE
    // -------------------------------------------------------------------------
    task automatic run_op(input logic [W:1] a, input logic [W:1] b, input logic c,
                          input logic [W:0] expv, input int hold, input string tag);
        logic [W:0] e;
        @(negedge CLK);
        chk({tag, "_in_ready"}, {{W{1'b0}}, IN_READY}, 1);
        IN_VALID = 1'b1;
        A = a;
        B = b;
        CIN = c;
        exp_q.push_back(expv);
        @(posedge CLK);
        #1;
        // Scramble inputs after acceptance; the DUT must have captured them.
        IN_VALID = 1'b0;
        A   = W'($urandom);
        B   = W'($urandom);
        CIN = 1'($urandom);
        chk({tag, "_busy"}, {{W{1'b0}}, BUSY}, 1);
        chk({tag, "_early_valid"}, {{W{1'b0}}, OUT_VALID}, 0);
        for (int k = 1; k < BEATS; k++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_early_valid"}, {{W{1'b0}}, OUT_VALID}, 0);
        end
        @(posedge CLK);
        #1;
        chk({tag, "_valid"}, {{W{1'b0}}, OUT_VALID}, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_result"}, {COUT, SUM}, e);
        chk({tag, "_in_ready_done"}, {{W{1'b0}}, IN_READY}, 0);
        repeat (hold) begin
            @(posedge CLK);
            #1;
            chk({tag, "_hold_valid"}, {{W{1'b0}}, OUT_VALID}, 1);
            chk({tag, "_hold_result"}, {COUT, SUM}, e);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk({tag, "_taken_valid"}, {{W{1'b0}}, OUT_VALID}, 0);
        chk({tag, "_taken_busy"}, {{W{1'b0}}, BUSY}, 0);
        chk({tag, "_idle_result"}, {COUT, SUM}, e);
        last_res = e;
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic [W:1] a;
        logic [W:1] b;
        logic       cin;
        logic [W:1] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[4];

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [W:1]  ra;
        logic [W:1]  rb;
        logic        rc;
        logic [W:0]  e1;
        logic [W:0]  e2;
        int          gap;

        vecs[0] = '{a: 16'h01E0, b: 16'h000F, cin: 1'b0, sum: 16'h01EF, cout: 1'b0};
        vecs[1] = '{a: 16'h01E0, b: 16'h000F, cin: 1'b1, sum: 16'h01F0, cout: 1'b0};
        vecs[2] = '{a: 16'hF1E0, b: 16'hF00F, cin: 1'b1, sum: 16'hE1F0, cout: 1'b1};
        vecs[3] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1};

        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        A         = '0;
        B         = '0;
        CIN       = 1'b0;
        OUT_READY = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_in_ready",  {{W{1'b0}}, IN_READY},  1);
        chk("rst_out_valid", {{W{1'b0}}, OUT_VALID}, 0);
        chk("rst_busy",      {{W{1'b0}}, BUSY},      0);
        chk("rst_result",    {COUT, SUM},            0);
        chk("rst_state",     {{(W-1){1'b0}}, DBG_STATE}, {{(W-1){1'b0}}, IDLE});
        @(negedge CLK);
        RST_N = 1'b1;

        // Table-driven known vectors
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, i, "vec");
        end

        // Backpressure with IN_VALID held high throughout
        ra = 16'h1234;
        rb = 16'h4321;
        @(negedge CLK);
        IN_VALID = 1'b1;
        A = ra;
        B = rb;
        CIN = 1'b0;
        e1 = ref_add(ra, rb, 1'b0);
        @(posedge CLK);
        #1;
        // Next operation staged on the inputs while the first one runs.
        A = 16'hAAAA;
        B = 16'h5556;
        CIN = 1'b1;
        e2 = ref_add(16'hAAAA, 16'h5556, 1'b1);
        repeat (BEATS) @(posedge CLK);
        #1;
        chk("bp_valid",  {{W{1'b0}}, OUT_VALID}, 1);
        chk("bp_result", {COUT, SUM}, e1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            chk("bp_hold_valid",    {{W{1'b0}}, OUT_VALID}, 1);
            chk("bp_hold_result",   {COUT, SUM}, e1);
            chk("bp_hold_in_ready", {{W{1'b0}}, IN_READY}, 0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("bp_taken_idle_ready", {{W{1'b0}}, IN_READY}, 1);
        chk("bp_taken_busy",       {{W{1'b0}}, BUSY}, 0);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        chk("bp_second_accepted", {{W{1'b0}}, BUSY}, 1);
        repeat (BEATS) @(posedge CLK);
        #1;
        chk("bp_second_valid",  {{W{1'b0}}, OUT_VALID}, 1);
        chk("bp_second_result", {COUT, SUM}, e2);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("bp_second_taken", {{W{1'b0}}, OUT_VALID}, 0);

        // Reset asserted after beat 0 of an operation
        @(negedge CLK);
        IN_VALID = 1'b1;
        A = 16'hFFFF;
        B = 16'h0001;
        CIN = 1'b0;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_out_valid", {{W{1'b0}}, OUT_VALID}, 0);
        chk("mid_rst_result",    {COUT, SUM}, 0);
        chk("mid_rst_busy",      {{W{1'b0}}, BUSY}, 0);
        chk("mid_rst_in_ready",  {{W{1'b0}}, IN_READY}, 1);
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("mid_rst_no_valid", {{W{1'b0}}, OUT_VALID}, 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            #1;
            chk("post_rst_no_valid", {{W{1'b0}}, OUT_VALID}, 0);
            chk("post_rst_result",   {COUT, SUM}, 0);
        end
        run_op(vecs[0].a, vecs[0].b, vecs[0].cin, {vecs[0].cout, vecs[0].sum}, 0, "post_rst");

        // Randomized operations against the arithmetic reference
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i % 6 == 0) begin
                ra = '1;
            end
            run_op(ra, rb, rc, ref_add(ra, rb, rc), $urandom_range(0, 3), "rand");
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge CLK);
                chk("idle_keep_result", {COUT, SUM}, last_res);
            end
        end

        chk("scoreboard_drained", W'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
